// File: rtl/sfifo_pkg.sv
// Shared constants, pointer type and helpers for the sfifo_ext family.
package sfifo_pkg;

  localparam string FwftTrue  = "true";
  localparam string FwftFalse = "false";

  // Widest legal pointer; instances narrow it to ADDR_WIDTH+1 bits.
  localparam int unsigned MaxAddrWidth = 16;
  typedef logic [MaxAddrWidth:0] ptr_t;

  function automatic ptr_t ptr_cnt(input ptr_t wr_ptr, input ptr_t rd_ptr,
                                   input int unsigned addr_width);
    ptr_t mask;
    mask = ptr_t'((1 << (addr_width + 1)) - 1);
    return (wr_ptr - rd_ptr) & mask;
  endfunction

endpackage

// File: rtl/sfifo_fwft_stage.sv
// Show-ahead output register: holds the head word and refills from RAM or,
// when RAM is empty, directly from the write port.
module sfifo_fwft_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr_acc,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_pop,
  input  logic             i_mem_empty,
  input  logic [WIDTH-1:0] i_mem_rdat,
  output logic             o_mem_wen,
  output logic             o_mem_ren,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;
  logic             w_need;
  logic             w_bypass;

  assign w_need    = ~r_vld | i_pop;
  // Writing straight into an empty stage keeps write-to-visible latency at one cycle.
  assign w_bypass  = w_need & i_mem_empty & i_wr_acc;
  assign o_mem_wen = i_wr_acc & ~w_bypass;
  assign o_mem_ren = w_need & ~i_mem_empty;
  assign o_vld     = r_vld;
  assign o_dat     = r_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_clr) begin
      r_vld <= 1'b0;
    end else if (o_mem_ren) begin
      r_vld <= 1'b1;
      r_dat <= i_mem_rdat;
    end else if (w_bypass) begin
      r_vld <= 1'b1;
      r_dat <= i_wdat;
    end else if (i_pop) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/simple_dpram_logic.sv
// Simple dual-port RAM: one write port, one read port, optional output register.
module simple_dpram_logic #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter string       DOUT_REG   = "false"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdat,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdat
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdat;
  end

  if (DOUT_REG == "true") begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     o_rdat <= '0;
      else if (i_ren) o_rdat <= r_mem[i_raddr];
    end
  end else begin : g_comb
    logic w_unused;
    assign w_unused = ^{rst_n, i_ren};
    assign o_rdat   = r_mem[i_raddr];
  end

endmodule

// File: rtl/sfifo_ext.sv
// Synchronous FIFO with optional FWFT read, occupancy count, thresholds,
// sticky overflow/underflow flags and synchronous flush.
module sfifo_ext import sfifo_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WIDTH      = 8,
  parameter string       FWFT       = FwftFalse
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_clr,
  input  logic                  fifo_wen,
  input  logic [WIDTH-1:0]      fifo_wdat,
  input  logic                  fifo_ren,
  output logic [WIDTH-1:0]      fifo_rdat,
  output logic                  fifo_rvld,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  input  logic [ADDR_WIDTH:0]   afull_th,
  input  logic [ADDR_WIDTH:0]   aempty_th,
  output logic                  fifo_afull,
  output logic                  fifo_aempty,
  output logic [ADDR_WIDTH:0]   fifo_cnt,
  output logic                  fifo_ovf,
  output logic                  fifo_udf
);

  localparam int unsigned         Depth  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CntMax = (ADDR_WIDTH + 1)'(Depth);

  typedef logic [ADDR_WIDTH:0] fifo_ptr_t;

  fifo_ptr_t           r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0] r_cnt;
  logic                r_ovf, r_udf;
  logic                w_full, w_empty, w_mem_empty;
  logic                w_wr_acc, w_rd_acc;
  logic                w_mem_wen, w_mem_ren;
  logic [WIDTH-1:0]    w_mem_rdat;

  assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
  // Flush wins over any request in the same cycle.
  assign w_wr_acc    = fifo_wen & ~w_full & ~fifo_clr;
  assign w_rd_acc    = fifo_ren & ~w_empty & ~fifo_clr;

  simple_dpram_logic #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (WIDTH),
    .DOUT_REG   ("false")
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wen   (w_mem_wen),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdat  (fifo_wdat),
    .i_ren   (w_mem_ren),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdat  (w_mem_rdat)
  );

  if (FWFT == FwftTrue) begin : g_fwft
    logic             w_stage_vld;
    logic [WIDTH-1:0] w_stage_dat;

    sfifo_fwft_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (fifo_clr),
      .i_wr_acc    (w_wr_acc),
      .i_wdat      (fifo_wdat),
      .i_pop       (w_rd_acc),
      .i_mem_empty (w_mem_empty),
      .i_mem_rdat  (w_mem_rdat),
      .o_mem_wen   (w_mem_wen),
      .o_mem_ren   (w_mem_ren),
      .o_vld       (w_stage_vld),
      .o_dat       (w_stage_dat)
    );

    // The stage word counts toward capacity, so full comes from the count.
    assign w_full    = (r_cnt == CntMax);
    assign w_empty   = ~w_stage_vld;
    assign fifo_rvld = w_stage_vld;
    assign fifo_rdat = w_stage_dat;
  end else begin : g_std
    logic [WIDTH-1:0] r_rdat;
    logic             r_rvld;

    assign w_full    = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                       (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_empty   = w_mem_empty;
    assign w_mem_wen = w_wr_acc;
    assign w_mem_ren = w_rd_acc;
    assign fifo_rvld = r_rvld;
    assign fifo_rdat = r_rdat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rdat <= '0;
        r_rvld <= 1'b0;
      end else begin
        r_rvld <= w_rd_acc;
        if (w_rd_acc) r_rdat <= w_mem_rdat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (fifo_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_mem_wen) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_mem_ren) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      r_ovf <= r_ovf | (fifo_wen & w_full);
      r_udf <= r_udf | (fifo_ren & w_empty);
    end
  end

  assign fifo_empty  = w_empty;
  assign fifo_full   = w_full;
  assign fifo_cnt    = r_cnt;
  assign fifo_ovf    = r_ovf;
  assign fifo_udf    = r_udf;
  assign fifo_afull  = (r_cnt >= afull_th);
  assign fifo_aempty = (r_cnt <= aempty_th);

endmodule

// File: tb/tb_sfifo_ext.sv
// Bench for sfifo_ext: a standard and an FWFT instance share stimulus and
// are checked against one queue-based reference model.
module tb_sfifo_ext;

  localparam int unsigned Aw    = 2;
  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_clr, fifo_wen, fifo_ren;
  logic [7:0] fifo_wdat;
  logic [2:0] afull_th, aempty_th;

  logic [7:0] s_rdat, f_rdat;
  logic       s_rvld, s_empty, s_full, s_afull, s_aempty, s_ovf, s_udf;
  logic       f_rvld, f_empty, f_full, f_afull, f_aempty, f_ovf, f_udf;
  logic [2:0] s_cnt, f_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_rdat = 8'h00;
  bit         m_rvld = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         m_udf  = 1'b0;

  always #5 clk = ~clk;

  sfifo_ext #(.ADDR_WIDTH(Aw), .WIDTH(8), .FWFT("false")) u_std (
    .clk (clk), .rst_n (rst_n), .fifo_clr (fifo_clr), .fifo_wen (fifo_wen),
    .fifo_wdat (fifo_wdat), .fifo_ren (fifo_ren), .fifo_rdat (s_rdat), .fifo_rvld (s_rvld),
    .fifo_empty (s_empty), .fifo_full (s_full), .afull_th (afull_th),
    .aempty_th (aempty_th), .fifo_afull (s_afull), .fifo_aempty (s_aempty),
    .fifo_cnt (s_cnt), .fifo_ovf (s_ovf), .fifo_udf (s_udf)
  );

  sfifo_ext #(.ADDR_WIDTH(Aw), .WIDTH(8), .FWFT("true")) u_fwft (
    .clk (clk), .rst_n (rst_n), .fifo_clr (fifo_clr), .fifo_wen (fifo_wen),
    .fifo_wdat (fifo_wdat), .fifo_ren (fifo_ren), .fifo_rdat (f_rdat), .fifo_rvld (f_rvld),
    .fifo_empty (f_empty), .fifo_full (f_full), .afull_th (afull_th),
    .aempty_th (aempty_th), .fifo_afull (f_afull), .fifo_aempty (f_aempty),
    .fifo_cnt (f_cnt), .fifo_ovf (f_ovf), .fifo_udf (f_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdat = 8'h00;
    m_rvld = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_edge(input bit wen, input logic [7:0] wd, input bit ren, input bit clr);
    bit full, empty;
    if (clr) begin
      q.delete();
      m_rvld = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      return;
    end
    full  = (q.size() == Depth);
    empty = (q.size() == 0);
    if (wen && full)  m_ovf = 1'b1;
    if (ren && empty) m_udf = 1'b1;
    m_rvld = 1'b0;
    if (ren && !empty) begin
      m_rdat = q.pop_front();
      m_rvld = 1'b1;
    end
    if (wen && !full) q.push_back(wd);
  endtask

  task automatic check_all(input string tag);
    int  n;
    bit  e_empty;
    n = q.size();
    e_empty = (n == 0);
    check({tag, ".s_cnt"},    s_cnt,    n);
    check({tag, ".s_empty"},  s_empty,  e_empty);
    check({tag, ".s_full"},   s_full,   n == Depth);
    check({tag, ".s_afull"},  s_afull,  n >= int'(afull_th));
    check({tag, ".s_aempty"}, s_aempty, n <= int'(aempty_th));
    check({tag, ".s_ovf"},    s_ovf,    m_ovf);
    check({tag, ".s_udf"},    s_udf,    m_udf);
    check({tag, ".s_rvld"},   s_rvld,   m_rvld);
    check({tag, ".s_rdat"},   s_rdat,   m_rdat);
    check({tag, ".f_cnt"},    f_cnt,    n);
    check({tag, ".f_empty"},  f_empty,  e_empty);
    check({tag, ".f_full"},   f_full,   n == Depth);
    check({tag, ".f_afull"},  f_afull,  n >= int'(afull_th));
    check({tag, ".f_aempty"}, f_aempty, n <= int'(aempty_th));
    check({tag, ".f_ovf"},    f_ovf,    m_ovf);
    check({tag, ".f_udf"},    f_udf,    m_udf);
    check({tag, ".f_rvld"},   f_rvld,   !e_empty);
    if (!e_empty) check({tag, ".f_rdat"}, f_rdat, q[0]);
  endtask

  // Drive one cycle of requests, clock it, then compare 1 time unit after the edge.
  task automatic step(input bit wen, input logic [7:0] wd, input bit ren, input bit clr,
                      input string tag);
    fifo_wen  = wen;
    fifo_wdat = wd;
    fifo_ren  = ren;
    fifo_clr  = clr;
    @(posedge clk);
    model_edge(wen, wd, ren, clr);
    #1;
    fifo_wen = 1'b0;
    fifo_ren = 1'b0;
    fifo_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] wseq [4];
    bit         ae_tab [5];
    bit         af_tab [5];
    wseq   = '{8'h11, 8'h22, 8'h33, 8'h44};
    ae_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    af_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n     = 1'b0;
    fifo_clr  = 1'b0;
    fifo_wen  = 1'b0;
    fifo_ren  = 1'b0;
    fifo_wdat = 8'h00;
    afull_th  = 3'd3;
    aempty_th = 3'd1;
    model_reset();
    #12;
    check_all("reset");
    check("reset.s_aempty_const", s_aempty, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill, overflow, drain in order
    for (int i = 0; i < 4; i++) step(1, wseq[i], 0, 0, "t1_wr");
    check("t1_full", s_full, 1'b1);
    check("t1_cnt4", s_cnt, 3'd4);
    step(1, 8'h55, 0, 0, "t1_ovf");
    check("t1_ovf_set", s_ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1, 0, "t1_rd");
      check("t1_rvld", s_rvld, 1'b1);
      check("t1_rdat", s_rdat, wseq[i]);
    end
    check("t1_empty", s_empty, 1'b1);

    // Underflow, then read+write while full
    step(0, 8'h00, 0, 1, "t2_clr");
    step(0, 8'h00, 1, 0, "t2_udf");
    check("t2_rvld0", s_rvld, 1'b0);
    check("t2_udf_set", s_udf, 1'b1);
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0, "t2_fill");
    step(1, 8'h66, 1, 0, "t2_full_rw");
    check("t2_cnt3", s_cnt, 3'd3);
    check("t2_ovf", s_ovf, 1'b1);

    // Steady-state streaming across pointer wrap
    step(0, 8'h00, 0, 1, "t3_clr");
    for (int i = 0; i < 3; i++) step(1, 8'h30 + 8'(i), 0, 0, "t3_fill");
    for (int i = 0; i < 12; i++) begin
      step(1, 8'hC0 + 8'(i), 1, 0, "t3_stream");
      check("t3_cnt3", s_cnt, 3'd3);
    end

    // Threshold flags across every occupancy
    step(0, 8'h00, 0, 1, "t4_clr");
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step(1, 8'h40 + 8'(c), 0, 0, "t4_wr");
      check("t4_aempty", s_aempty, ae_tab[c]);
      check("t4_afull", s_afull, af_tab[c]);
    end

    // FWFT show-ahead behaviour
    step(0, 8'h00, 0, 1, "t5_clr");
    step(1, 8'hA5, 0, 0, "t5_wr_a5");
    check("t5_f_empty0", f_empty, 1'b0);
    check("t5_f_rdat_a5", f_rdat, 8'hA5);
    step(1, 8'hB6, 0, 0, "t5_wr_b6");
    step(0, 8'h00, 1, 0, "t5_pop1");
    check("t5_f_rdat_b6", f_rdat, 8'hB6);
    step(0, 8'h00, 1, 0, "t5_pop2");
    check("t5_f_empty1", f_empty, 1'b1);

    // Flush with a simultaneous write, then asynchronous reset mid-burst
    step(0, 8'h00, 0, 1, "t6_clr0");
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0, "t6_fill");
    step(0, 8'h00, 1, 0, "t6_rd");
    step(0, 8'h00, 1, 0, "t6_rd");
    check("t6_pre_cnt2", s_cnt, 3'd2);
    check("t6_pre_ovf", s_ovf, 1'b1);
    step(1, 8'h77, 0, 1, "t6_clr_wen");
    check("t6_cnt0", s_cnt, 3'd0);
    check("t6_empty", f_empty, 1'b1);
    check("t6_ovf0", f_ovf, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 8'h80 + 8'(i), 0, 0, "t6_burst");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_areset");
    check("t6_areset_cnt", f_cnt, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with occasional flush and threshold changes
    for (int i = 0; i < 400; i++) begin
      bit         w, r, c;
      logic [7:0] d;
      if (i % 50 == 0) begin
        afull_th  = 3'($urandom_range(0, 7));
        aempty_th = 3'($urandom_range(0, 7));
      end
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 3);
      d = 8'($urandom);
      step(w, d, r, c, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
